vga_capture: RTL
================

// Module: vga_capture
// PURPOSE
//  Receiving end of the VGA link: samples hs/vs/RGB on the pixel clock, tracks line and frame
//  timing against the configured geometry, and recovers a pixel stream with x/y coordinates.
//  Used as a loopback checker for the display path and as a frame-grab front end.
//  Flags every timing violation, drops lock on error and relocks without intervention.
// PARAMETERS
//  width_p 640 / height_p 480: active pixels per line / active lines per frame
//  h_sync_pulse_p 96, h_sync_back_porch_p 48, h_sync_front_porch_p 16: horizontal timing (clocks)
//  v_sync_pulse_p 2, v_sync_back_porch_p 33, v_sync_front_porch_p 10: vertical timing (lines)
//  bit_depth 8: bits per colour channel
//  Derived: R = sum of horizontal terms (800 default), C = sum of vertical terms (525 default)
// PORTS
//  clk_i      in  1   pixel clock; hs/vs/RGB are synchronous to it (no CDC in this block)
//  reset_i    in  1   synchronous, active-high reset
//  hs_i, vs_i in  1   sync inputs, active-high pulses
//  r_i/g_i/b_i in bit_depth  colour inputs
//  x_o        out $clog2(width_p)   pixel column, 0..width_p-1
//  y_o        out $clog2(height_p)  pixel row, 0..height_p-1
//  r_o/g_o/b_o out bit_depth  captured colour
//  pix_v_o    out 1   x_o/y_o/RGB valid this cycle
//  frame_start_o out 1  with pix_v_o on pixel (0,0)
//  locked_o   out 1   timing lock held
//  err_o      out 1   one-cycle pulse per detected violation
//  err_cnt_o  out 8   violations since reset, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0, FSM UNLOCKED, counters 0. Reset mid-frame aborts immediately.
//  Stage 0 registers hs/vs/RGB; all detection works on stage 0; outputs are registered:
//   input sampled at edge t appears on outputs after edge t+1 (2-cycle latency).
//  Rise/fall = stage-0 value vs its previous-cycle value.
//  hcnt ($clog2(R) bits) = index of current sample in line: 0 on hs rise, else prev+1.
//  vcnt ($clog2(C) bits) updated on hs rise only: 0 if vs also rises that sample, else prev+1.
//  Active pixel: hcnt in [HP+HBP, HP+HBP+width_p-1], vcnt in [VP+VBP, VP+VBP+height_p-1];
//   x = hcnt-HP-HBP, y = vcnt-VP-VBP (HP/HBP/VP/VBP = pulse/back-porch params).
//  Violations (checked in SYNC and LOCKED only):
//   hs rise with prev hcnt != R-1; no hs rise with prev hcnt == R-1;
//   hs fall at hcnt != HP;  vs rise not on an hs-rise sample;
//   vs rise with prev vcnt != C-1; hs rise without vs rise with prev vcnt == C-1;
//   at each hs rise, vs level != (new vcnt < VP).
//  FSM: UNLOCKED -> SYNC on vs rise coincident with hs rise (counters set to 0).
//   SYNC -> LOCKED on next vs rise with no violation in between; locked_o 1 from next output.
//   SYNC/LOCKED -> UNLOCKED on any violation; err_o=1, locked_o=0, pix_v_o=0 on same output
//   cycle; err_cnt_o +1 (saturating). Violating sample may itself start SYNC if it is a valid
//   coincident hs+vs rise.
//  pix_v_o only in LOCKED; outside active region x_o/y_o/RGB hold last values.
//  Simultaneous violations in one sample count as one error.
// TESTING
//  1 Default params, generator model drawing R=x[7:0], G=y[7:0], B=x^y -> locked_o rises after
//    2nd vs rise; per frame exactly 307200 pix_v_o, one frame_start_o at (0,0), RGB matches x/y.
//  2 Locked, one line 799 clocks -> err_o pulse at offending hs rise, locked_o/pix_v_o 0,
//    err_cnt_o=1; relock after next two clean vs rises.
//  3 Locked, hs pulse 95 clocks -> err_o on fall sample (hcnt=95), err_cnt_o increments.
//  4 Locked, vs suppressed for one frame -> err_o at hs rise following vcnt=524, unlocks.
//  5 reset_i for 1 cycle mid-line while locked -> all outputs 0 next cycle; normal relock.
//  6 width_p=4,height_p=3, pulses/porches=1 -> exhaustive x/y order per frame; 300 injected
//    errors -> err_cnt_o saturates at 255.

Source files
------------

// File: rtl/vga_capture_if.sv
// Signal bundle between a VGA source and the capture block.
// Sync and colour flow in; the recovered pixel stream and lock/error status flow out.
interface vga_capture_if #(
    parameter int width_p   = 640,
    parameter int height_p  = 480,
    parameter int bit_depth = 8
);
    localparam int XW = (width_p  > 1) ? $clog2(width_p)  : 1;
    localparam int YW = (height_p > 1) ? $clog2(height_p) : 1;

    logic                 hs_i, vs_i;
    logic [bit_depth-1:0] r_i, g_i, b_i;
    logic [XW-1:0]        x_o;
    logic [YW-1:0]        y_o;
    logic [bit_depth-1:0] r_o, g_o, b_o;
    logic                 pix_v_o, frame_start_o, locked_o, err_o;
    logic [7:0]           err_cnt_o;

    modport master (
        output hs_i, vs_i, r_i, g_i, b_i,
        input  x_o, y_o, r_o, g_o, b_o, pix_v_o, frame_start_o, locked_o, err_o, err_cnt_o
    );
    modport slave (
        input  hs_i, vs_i, r_i, g_i, b_i,
        output x_o, y_o, r_o, g_o, b_o, pix_v_o, frame_start_o, locked_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/vga_capture.sv
// VGA receiver: registers sync/colour, tracks line/frame position against the configured
// geometry, flags timing violations and emits an x/y-tagged pixel stream while locked.
module vga_capture #(
    parameter int width_p              = 640,
    parameter int height_p             = 480,
    parameter int h_sync_pulse_p       = 96,
    parameter int h_sync_back_porch_p  = 48,
    parameter int h_sync_front_porch_p = 16,
    parameter int v_sync_pulse_p       = 2,
    parameter int v_sync_back_porch_p  = 33,
    parameter int v_sync_front_porch_p = 10,
    parameter int bit_depth            = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    vga_capture_if.slave bus
);
    localparam int R  = h_sync_pulse_p + h_sync_back_porch_p + width_p + h_sync_front_porch_p;
    localparam int C  = v_sync_pulse_p + v_sync_back_porch_p + height_p + v_sync_front_porch_p;
    localparam int HW = $clog2(R);
    localparam int VW = $clog2(C);
    localparam int XW = (width_p  > 1) ? $clog2(width_p)  : 1;
    localparam int YW = (height_p > 1) ? $clog2(height_p) : 1;

    localparam logic [HW-1:0] H_LAST  = HW'(R - 1);
    localparam logic [HW-1:0] H_PULSE = HW'(h_sync_pulse_p);
    localparam logic [HW-1:0] H_ACT0  = HW'(h_sync_pulse_p + h_sync_back_porch_p);
    localparam logic [HW-1:0] H_ACT1  = HW'(h_sync_pulse_p + h_sync_back_porch_p + width_p - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(C - 1);
    localparam logic [VW-1:0] V_PULSE = VW'(v_sync_pulse_p);
    localparam logic [VW-1:0] V_ACT0  = VW'(v_sync_pulse_p + v_sync_back_porch_p);
    localparam logic [VW-1:0] V_ACT1  = VW'(v_sync_pulse_p + v_sync_back_porch_p + height_p - 1);

    typedef enum logic [1:0] {ST_UNLOCKED, ST_SYNC, ST_LOCKED} state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_hs0, r_vs0, r_hs_prev, r_vs_prev;
    logic [bit_depth-1:0] r_r0, r_g0, r_b0;
    logic [HW-1:0]        r_hcnt, w_hcnt;
    logic [VW-1:0]        r_vcnt, w_vcnt;
    logic                 w_hs_rise, w_hs_fall, w_vs_rise, w_start;
    logic                 w_viol, w_err, w_locked, w_active;
    logic [XW-1:0]        w_x, r_x;
    logic [YW-1:0]        w_y, r_y;
    logic [bit_depth-1:0] r_r, r_g, r_b;
    logic                 r_pix_v, r_fs, r_locked, r_err;
    logic [7:0]           r_err_cnt;

    // Stage 0 sample plus the position counters that describe it (used as "prev" next cycle).
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_hs0     <= 1'b0;
            r_vs0     <= 1'b0;
            r_hs_prev <= 1'b0;
            r_vs_prev <= 1'b0;
            r_r0      <= '0;
            r_g0      <= '0;
            r_b0      <= '0;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_state   <= ST_UNLOCKED;
        end else begin
            r_hs0     <= bus.hs_i;
            r_vs0     <= bus.vs_i;
            r_hs_prev <= r_hs0;
            r_vs_prev <= r_vs0;
            r_r0      <= bus.r_i;
            r_g0      <= bus.g_i;
            r_b0      <= bus.b_i;
            r_hcnt    <= w_hcnt;
            r_vcnt    <= w_vcnt;
            r_state   <= w_state_nxt;
        end
    end

    always_comb begin
        w_hs_rise = r_hs0 & ~r_hs_prev;
        w_hs_fall = ~r_hs0 & r_hs_prev;
        w_vs_rise = r_vs0 & ~r_vs_prev;
        w_start   = w_hs_rise & w_vs_rise;
        w_hcnt    = w_hs_rise ? '0 : r_hcnt + 1'b1;
        w_vcnt    = r_vcnt;
        if (w_hs_rise)
            w_vcnt = w_vs_rise ? '0 : r_vcnt + 1'b1;
        // Any number of simultaneous violations collapse into a single error.
        w_viol = (w_hs_rise && r_hcnt != H_LAST)
              || (!w_hs_rise && r_hcnt == H_LAST)
              || (w_hs_fall && w_hcnt != H_PULSE)
              || (w_vs_rise && !w_hs_rise)
              || (w_vs_rise && r_vcnt != V_LAST)
              || (w_hs_rise && !w_vs_rise && r_vcnt == V_LAST)
              || (w_hs_rise && (r_vs0 != (w_vcnt < V_PULSE)));
        w_err    = (r_state != ST_UNLOCKED) && w_viol;
        w_active = (w_hcnt >= H_ACT0) && (w_hcnt <= H_ACT1)
                && (w_vcnt >= V_ACT0) && (w_vcnt <= V_ACT1);
        w_x      = XW'(w_hcnt - H_ACT0);
        w_y      = YW'(w_vcnt - V_ACT0);
    end

    // A violating sample that is itself a clean frame start re-enters SYNC directly.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_UNLOCKED: if (w_start) w_state_nxt = ST_SYNC;
            ST_SYNC: begin
                if (w_err)          w_state_nxt = w_start ? ST_SYNC : ST_UNLOCKED;
                else if (w_vs_rise) w_state_nxt = ST_LOCKED;
            end
            ST_LOCKED: if (w_err) w_state_nxt = w_start ? ST_SYNC : ST_UNLOCKED;
            default: w_state_nxt = ST_UNLOCKED;
        endcase
        w_locked = (w_state_nxt == ST_LOCKED);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_x       <= '0;
            r_y       <= '0;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
            r_pix_v   <= 1'b0;
            r_fs      <= 1'b0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_pix_v  <= w_locked & w_active;
            r_fs     <= w_locked & w_active & (w_hcnt == H_ACT0) & (w_vcnt == V_ACT0);
            r_locked <= w_locked;
            r_err    <= w_err;
            if (w_err && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
            // Data outputs only move inside the active window; elsewhere they hold.
            if (w_active) begin
                r_x <= w_x;
                r_y <= w_y;
                r_r <= r_r0;
                r_g <= r_g0;
                r_b <= r_b0;
            end
        end
    end

    assign bus.x_o           = r_x;
    assign bus.y_o           = r_y;
    assign bus.r_o           = r_r;
    assign bus.g_o           = r_g;
    assign bus.b_o           = r_b;
    assign bus.pix_v_o       = r_pix_v;
    assign bus.frame_start_o = r_fs;
    assign bus.locked_o      = r_locked;
    assign bus.err_o         = r_err;
    assign bus.err_cnt_o     = r_err_cnt;
endmodule
